gmii_rx_deframer: RTL and testbench
===================================

# gmii_rx_deframer

Receive-side GMII deframer for the qvip_ethernet_parallel bench; the DUT end that consumes frames driven by the QVIP Ethernet transmitter. Strips preamble/SFD and FCS, checks CRC-32 and length, and emits the payload byte stream with per-frame status on the last beat. Also keeps good/bad frame counters for scoreboard cross-check.

## Interface
- MIN_LEN, 64, minimum legal frame length in bytes after SFD, including FCS
- MAX_LEN, 1518, maximum legal frame length in bytes after SFD, including FCS
- CNT_W, 32, width of frame counters
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-low reset
- gmii_rxd  in  8  receive data
- gmii_rx_dv  in  1  receive data valid
- gmii_rx_er  in  1  receive error
- m_valid  out  1  payload byte valid; no backpressure
- m_data  out  8  payload byte
- m_last  out  1  last payload byte of frame
- m_status  out  4  {giant, runt, rx_er_seen, crc_bad}; meaningful only with m_last
- good_frames  out  CNT_W  frames ending with m_status==0
- bad_frames  out  CNT_W  frames ending with nonzero status, or too short to emit

## Operation
- Reset: all outputs 0, counters 0, FSM to DROP.
- States: IDLE, PREAMBLE, DATA, DROP.
- IDLE: rx_dv=1 & rxd=0x55 -> PREAMBLE; rx_dv=1 & rxd=0xD5 -> DATA; rx_dv=1 with any other byte -> DROP; rx_er in IDLE ignored.
- PREAMBLE: 0x55 stays; 0xD5 -> DATA; other byte -> DROP; rx_dv=0 -> IDLE. No counter update.
- DATA: each sampled byte (index k, from 0) enters a 5-deep shift line, updates CRC, increments saturating 16-bit length L. rx_er=1 with rx_dv=1 sets rx_er_seen.
- Emit: once 5 entries are held, each new byte shifts the oldest out onto m_data with m_valid=1.
- End of frame (rx_dv=0 sampled in DATA): if L>=5, oldest entry (byte L-5) is emitted with m_last=1 and m_status; remaining 4 entries (FCS) are discarded. If L<5, no beats, bad_frames+1. FSM -> IDLE.
- CRC: LSB-first reflected CRC-32 (poly 0xEDB88320), init 0xFFFFFFFF, over bytes 0..L-1 including FCS; crc_bad = register != 0xDEBB20E3.
- runt = L<MIN_LEN; giant = L>MAX_LEN. Length saturates at 0xFFFF; frame keeps streaming.
- Counters increment on the m_last cycle, wrap at 2^CNT_W.
- DROP: wait for rx_dv=0, then IDLE. Covers rx_dv high out of reset.

## Timing
- Byte k sampled at edge E_k appears registered on m_data after edge E_{k+5}; byte L-5 appears after the edge that samples rx_dv=0. Latency exactly 5 cycles; m_valid high for L-4 contiguous cycles.
- m_valid, m_last, m_status are single-cycle registered outputs; m_status=0 when m_last=0.
- Minimum IPG of 1 idle cycle supported: end emission and IDLE entry occur on the same edge, next preamble sampled the following cycle.
- Reset mid-frame: outputs clear on that edge, no partial last beat, no counter update, FSM to DROP.

## Structure
- Package gmii_rx_pkg: PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, CRC_POLY, CRC_INIT, CRC_RESIDUE, typedef packed struct gmii_rx_status_t {giant, runt, rx_er_seen, crc_bad}, FSM state enum.
- Sub-module crc32_d8: combinational next-CRC for one byte (crc_in[31:0], data[7:0] -> crc_out[31:0]); state register kept in deframer.

## Test plan
- 7x0x55, 0xD5, 60-byte incrementing payload 0x00..0x3B + correct FCS -> 60 beats 0x00..0x3B, m_last on 0x3B, m_status=0, good_frames=1, first beat 5 cycles after byte 0.
- Same frame with one payload bit flipped -> 60 beats, m_status=4'b0001, bad_frames=1.
- rx_er=1 on byte 10 of a valid 64-byte frame -> m_status=4'b0010; 20-byte frame with good FCS -> 4'b0100; 1600-byte frame -> 4'b1000.
- Two 64-byte good frames separated by one idle cycle -> 120 beats, two m_last pulses, good_frames=2.
- Preamble 0x55,0x55,0x12,... then data -> no beats, no counter change; frame with 3 bytes after SFD -> no beats, bad_frames+1.
- rst asserted at byte 30 of a frame, released while rx_dv still high -> no beats until rx_dv low; next good frame received correctly, counters reflect only it.

Source files
------------

// File: rtl/gmii_rx_pkg.sv
// Shared constants, status layout and FSM encoding for the GMII receive deframer.
package gmii_rx_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
  // Delay line depth: one payload byte plus the four FCS bytes held back
  localparam int          LINE_DEPTH    = 5;

  typedef struct packed {
    logic giant;
    logic runt;
    logic rx_er_seen;
    logic crc_bad;
  } gmii_rx_status_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DROP
  } rx_state_t;

endpackage

// File: rtl/crc32_d8.sv
// One-byte step of the reflected (LSB-first) Ethernet CRC-32; purely combinational.
module crc32_d8
  import gmii_rx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ (((c[0] ^ data[i]) == 1'b1) ? CRC_POLY : 32'h0);
    end
    crc_out = c;
  end

endmodule

// File: rtl/gmii_rx_deframer.sv
// GMII receive deframer: strips preamble/SFD and FCS, checks CRC and length,
// streams payload bytes with status on the last beat and counts good/bad frames.
module gmii_rx_deframer
  import gmii_rx_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       gmii_rxd,
  input  logic             gmii_rx_dv,
  input  logic             gmii_rx_er,
  output logic             m_valid,
  output logic [7:0]       m_data,
  output logic             m_last,
  output logic [3:0]       m_status,
  output logic [CNT_W-1:0] good_frames,
  output logic [CNT_W-1:0] bad_frames
);

  localparam logic [15:0] MIN_LEN_L = 16'(MIN_LEN);
  localparam logic [15:0] MAX_LEN_L = 16'(MAX_LEN);
  localparam logic [2:0]  FULL_CNT  = 3'(LINE_DEPTH);

  rx_state_t       state;
  logic [7:0]      byte_line [LINE_DEPTH];
  logic [2:0]      fill;
  logic [15:0]     len;
  logic            er_seen;
  logic [31:0]     crc_q;
  logic [31:0]     crc_next;
  logic            line_full;
  gmii_rx_status_t end_status;

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data    (gmii_rxd),
    .crc_out (crc_next)
  );

  assign line_full = (fill == FULL_CNT);

  always_comb begin
    end_status            = '0;
    end_status.giant      = (len > MAX_LEN_L);
    end_status.runt       = (len < MIN_LEN_L);
    end_status.rx_er_seen = er_seen;
    end_status.crc_bad    = (crc_q != CRC_RESIDUE);
  end

  // Datapath: delay line and CRC register, restarted whenever we are outside a frame
  always_ff @(posedge clk) begin
    if (state == ST_DATA && gmii_rx_dv) begin
      byte_line[0] <= gmii_rxd;
      for (int i = 1; i < LINE_DEPTH; i++) begin
        byte_line[i] <= byte_line[i-1];
      end
      crc_q <= crc_next;
    end else if (state != ST_DATA) begin
      crc_q <= CRC_INIT;
    end
  end

  // Control: FSM, frame bookkeeping and registered output beat
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_DROP;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      m_status    <= '0;
      m_data      <= '0;
      good_frames <= '0;
      bad_frames  <= '0;
      fill        <= '0;
      len         <= '0;
      er_seen     <= 1'b0;
    end else begin
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      m_status <= '0;
      if (state != ST_DATA) begin
        fill    <= '0;
        len     <= '0;
        er_seen <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (gmii_rx_dv) begin
            if (gmii_rxd == PREAMBLE_BYTE)  state <= ST_PREAMBLE;
            else if (gmii_rxd == SFD_BYTE)  state <= ST_DATA;
            else                            state <= ST_DROP;
          end
        end
        ST_PREAMBLE: begin
          if (!gmii_rx_dv)                  state <= ST_IDLE;
          else if (gmii_rxd == SFD_BYTE)    state <= ST_DATA;
          else if (gmii_rxd != PREAMBLE_BYTE) state <= ST_DROP;
        end
        ST_DATA: begin
          if (gmii_rx_dv) begin
            if (line_full) begin
              m_valid <= 1'b1;
              m_data  <= byte_line[LINE_DEPTH-1];
            end else begin
              fill <= fill + 3'd1;
            end
            if (len != 16'hFFFF) len <= len + 16'd1;
            if (gmii_rx_er) er_seen <= 1'b1;
          end else begin
            state <= ST_IDLE;
            // Oldest entry is the final payload byte; the four newer ones are FCS
            if (line_full) begin
              m_valid  <= 1'b1;
              m_last   <= 1'b1;
              m_data   <= byte_line[LINE_DEPTH-1];
              m_status <= end_status;
              if (end_status == '0) good_frames <= good_frames + CNT_W'(1);
              else                  bad_frames  <= bad_frames + CNT_W'(1);
            end else begin
              bad_frames <= bad_frames + CNT_W'(1);
            end
          end
        end
        ST_DROP: begin
          if (!gmii_rx_dv) state <= ST_IDLE;
        end
        default: state <= ST_DROP;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// Scoreboard bench for gmii_rx_deframer: directed frames push expected beats,
// a negedge monitor pops and compares every beat including its arrival cycle.
module tb_gmii_rx_deframer;

  logic        clk;
  logic        rst;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv;
  logic        gmii_rx_er;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_last;
  logic [3:0]  m_status;
  logic [31:0] good_frames;
  logic [31:0] bad_frames;

  gmii_rx_deframer #(.MIN_LEN(64), .MAX_LEN(1518), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .gmii_rxd    (gmii_rxd),
    .gmii_rx_dv  (gmii_rx_dv),
    .gmii_rx_er  (gmii_rx_er),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_last      (m_last),
    .m_status    (m_status),
    .good_frames (good_frames),
    .bad_frames  (bad_frames)
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic [3:0] s;
    int         c;
  } beat_t;

  beat_t       sb[$];
  int          cyc;
  int          n_checks;
  int          n_fail;
  logic [7:0]  frm [0:2047];
  int          flen;
  logic [31:0] exp_good;
  logic [31:0] exp_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Byte-at-a-time reflected CRC: xor the byte in, then eight conditional shifts
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic build_frame(input int n);
    logic [31:0] crc;
    logic [31:0] fcs;
    crc = 32'hFFFFFFFF;
    for (int k = 0; k < n; k++) begin
      frm[k] = k[7:0];
      crc = crc_step(crc, frm[k]);
    end
    fcs = ~crc;
    frm[n]   = fcs[7:0];
    frm[n+1] = fcs[15:8];
    frm[n+2] = fcs[23:16];
    frm[n+3] = fcs[31:24];
    flen = n + 4;
  endtask

  task automatic drive(input logic dv, input logic er, input logic [7:0] d);
    @(negedge clk);
    gmii_rx_dv = dv;
    gmii_rx_er = er;
    gmii_rxd   = d;
  endtask

  // Byte k driven at negedge with cyc=n is sampled at the edge making cyc=n+1;
  // its beat is registered five edges later, seen at the negedge with cyc=n+6.
  task automatic send_frame(input logic [3:0] st, input int er_idx, input int rst_at, input int ipg);
    beat_t b;
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int k = 0; k < flen; k++) begin
      drive(1'b1, k == er_idx, frm[k]);
      rst = (k == rst_at) ? 1'b0 : 1'b1;
      if (k <= flen - 5 && (rst_at < 0 || k + 5 < rst_at)) begin
        b.d = frm[k];
        b.l = (k == flen - 5);
        b.s = (k == flen - 5) ? st : 4'b0000;
        b.c = cyc + 6;
        sb.push_back(b);
      end
    end
    if (rst_at >= 0) begin
      exp_good = 0;
      exp_bad  = 0;
    end else if (flen < 5 || st != 4'b0000) begin
      exp_bad = exp_bad + 1;
    end else begin
      exp_good = exp_good + 1;
    end
    for (int i = 0; i < ipg; i++) drive(1'b0, 1'b0, 8'h00);
    rst = 1'b1;
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic check_cnts(input string name);
    @(negedge clk);
    check_val({name, "_good"}, good_frames, exp_good);
    check_val({name, "_bad"},  bad_frames,  exp_bad);
  endtask

  // Monitor: every beat must match the head of the scoreboard, including arrival cycle
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (m_valid === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got data=%h last=%b status=%b at cyc %0d, required no beat",
                   m_data, m_last, m_status, cyc);
        end else begin
          e = sb.pop_front();
          if (m_data !== e.d || m_last !== e.l || m_status !== e.s || cyc != e.c) begin
            n_fail++;
            $display("FAIL beat: got data=%h last=%b status=%b cyc=%0d, required data=%h last=%b status=%b cyc=%0d",
                     m_data, m_last, m_status, cyc, e.d, e.l, e.s, e.c);
          end
        end
      end else if (m_last !== 1'b0 || m_status !== 4'b0000) begin
        n_checks++;
        n_fail++;
        $display("FAIL idle_outputs: got last=%b status=%b, required 0 and 0000", m_last, m_status);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_good = 0;
    exp_bad  = 0;
    rst = 1'b0;
    gmii_rx_dv = 1'b1;
    gmii_rx_er = 1'b0;
    gmii_rxd   = 8'hAB;

    // Reset held with rx_dv high; afterwards the deframer must sit in DROP
    repeat (3) @(negedge clk);
    check_val("rst_m_valid",  {31'h0, m_valid}, 32'h0);
    check_val("rst_m_last",   {31'h0, m_last},  32'h0);
    check_val("rst_m_status", {28'h0, m_status}, 32'h0);
    check_val("rst_m_data",   {24'h0, m_data},  32'h0);
    check_val("rst_good",     good_frames, 32'h0);
    check_val("rst_bad",      bad_frames,  32'h0);
    rst = 1'b1;
    drive(1'b1, 1'b0, 8'hD5);
    drive(1'b1, 1'b0, 8'h55);
    repeat (4) drive(1'b1, 1'b0, 8'h11);
    repeat (2) drive(1'b0, 1'b0, 8'h00);
    check_cnts("after_reset_drop");

    // Good 64-byte frame
    build_frame(60);
    send_frame(4'b0000, -1, -1, 3);
    check_cnts("good64");

    // Payload bit flipped after FCS computed
    build_frame(60);
    frm[5] = frm[5] ^ 8'h01;
    send_frame(4'b0001, -1, -1, 3);
    check_cnts("crc_bad");

    // rx_er on byte 10
    build_frame(60);
    send_frame(4'b0010, 10, -1, 3);
    check_cnts("rx_er");

    // Runt: 20 bytes incl. FCS
    build_frame(16);
    send_frame(4'b0100, -1, -1, 3);
    check_cnts("runt");

    // Giant: 1600 bytes incl. FCS
    build_frame(1596);
    send_frame(4'b1000, -1, -1, 3);
    check_cnts("giant");

    // Two good frames separated by a single idle cycle
    build_frame(60);
    send_frame(4'b0000, -1, -1, 1);
    send_frame(4'b0000, -1, -1, 2);
    check_cnts("back_to_back");

    // Bad byte inside preamble: whole burst dropped
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'h12);
    drive(1'b1, 1'b0, 8'hD5);
    for (int k = 0; k < 20; k++) drive(1'b1, 1'b0, k[7:0]);
    repeat (2) drive(1'b0, 1'b0, 8'h00);
    check_cnts("bad_preamble");

    // Three bytes after SFD: too short to emit
    flen = 3;
    frm[0] = 8'hA1;
    frm[1] = 8'hB2;
    frm[2] = 8'hC3;
    send_frame(4'b0000, -1, -1, 3);
    check_cnts("short3");

    // Reset on byte 30, released while rx_dv stays high, then a clean frame
    build_frame(60);
    send_frame(4'b0000, -1, 30, 3);
    check_cnts("mid_reset");
    send_frame(4'b0000, -1, -1, 3);
    check_cnts("after_mid_reset");

    repeat (10) @(negedge clk);
    check_val("missing_beats", sb.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
